// File: rtl/afifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port; grant 1 cycle after request, 1 word/cycle in burst.
// Backpressure: FifoFull_in blocks the write and Ack in the same cycle; owner, beat and state hold.
module afifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          Clk,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ-1:0]            Last_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  output logic [NUM_REQ-1:0]            Ack_out,
  output logic [NUM_REQ-1:0]            Grant_out,
  output logic                          Busy_out,
  output logic [DATA_WIDTH-1:0]         FifoData_out,
  output logic                          FifoWriteEn_out,
  input  logic                          FifoFull_in
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr;
  logic [BEAT_W-1:0]   beat;
  logic [NUM_REQ-1:0]  grant_q;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  int                  idx;
  logic                wr_en;
  logic                burst_end;

  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (Req_in[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
  end

  assign wr_en     = (state == BURST) & Req_in[owner] & ~FifoFull_in & ~Clear_in;
  assign burst_end = wr_en & (Last_in[owner] | (beat == BEAT_W'(MAX_BURST - 1)));

  assign FifoWriteEn_out = wr_en;
  assign Ack_out         = wr_en ? (NUM_REQ'(1) << owner) : '0;
  assign Grant_out       = Clear_in ? '0 : grant_q;
  assign Busy_out        = (state == BURST) & ~Clear_in;
  assign FifoData_out    = ((state == BURST) && !Clear_in) ?
                           Data_in[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      state   <= IDLE;
      owner   <= '0;
      rr      <= '0;
      beat    <= '0;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= BURST;
            owner   <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
            beat    <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state   <= IDLE;
            grant_q <= '0;
            beat    <= '0;
            rr      <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          end else if (wr_en) begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
